// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage: WIDTH-bit words in over valid/ready, one bit per clk on x_out.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
//
// state  | meaning
// IDLE   | no word in flight, x_out at IDLE_BIT, ready for a word
// SHIFT  | x_out carries data bit cnt of the current word
// PARITY | x_out carries the even parity of the word (SERIALIZER_PARITY_EN only)
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             x_out,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic             x_nxt;
    logic             accept;
    logic             last_bit;
`ifdef SERIALIZER_PARITY_EN
    logic             par, par_nxt;
`endif

    // Bit that leaves the word first in transmit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

`ifdef SERIALIZER_PARITY_EN
    assign in_ready = rst_n && ((state == IDLE) || (state == PARITY));
`else
    assign in_ready = rst_n && ((state == IDLE) || last_bit);
`endif

    assign accept      = in_valid && in_ready;
    assign busy        = (state != IDLE);
    assign x_valid     = (state != IDLE);
    assign frame_start = (state == SHIFT) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            x_out <= IDLE_BIT;
`ifdef SERIALIZER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
            x_out <= x_nxt;
`ifdef SERIALIZER_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

    // An accept on the final bit reloads directly, so back-to-back words have no gap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        x_nxt     = x_out;
`ifdef SERIALIZER_PARITY_EN
        par_nxt   = par;
`endif
        if (accept) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
            sreg_nxt  = advance(in_data);
            x_nxt     = first_bit(in_data);
`ifdef SERIALIZER_PARITY_EN
            par_nxt   = ^in_data;
`endif
        end else begin
            case (state)
                IDLE: begin
                    x_nxt = IDLE_BIT;
                end
                SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
`ifdef SERIALIZER_PARITY_EN
                        state_nxt = PARITY;
                        x_nxt     = par;
`else
                        state_nxt = IDLE;
                        x_nxt     = IDLE_BIT;
`endif
                    end else begin
                        cnt_nxt  = cnt + 1'b1;
                        x_nxt    = first_bit(sreg);
                        sreg_nxt = advance(sreg);
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                PARITY: begin
                    state_nxt = IDLE;
                    x_nxt     = IDLE_BIT;
                end
`endif
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    x_nxt     = IDLE_BIT;
                end
            endcase
        end
    end

endmodule
